// File: rtl/studio2_keypad.sv
// rtl/studio2_keypad.sv - Studio II dual keypad scanner driving cdp1802 EF3/EF4 from PS/2 key events
// Optional feature macro: STUDIO2_KEYPAD_HOLD_EN (minimum assert time for tapped keys)
module studio2_keypad #(
    parameter logic [2:0] SEL_PORT    = 3'd2,
    parameter int         HOLD_CYCLES = 100000,
    parameter int         HOLD_W      = 17
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        io_out,
    input  logic [2:0]  io_n,
    input  logic [7:0]  io_dout,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [3:0]  key_sel,
    output logic [9:0]  kp1_state,
    output logic [9:0]  kp2_state
);

    // A counter too narrow for the hold time would wrap and never expire
    if ((2 ** HOLD_W) <= HOLD_CYCLES) begin : g_hold_w_check
        $error("HOLD_W too narrow for HOLD_CYCLES");
    end

    // Scancode to combined bitmap index: keypad 1 digits at 0..9, keypad 2 at 10..19.
    // Result is {valid, index}.
    function automatic logic [5:0] decode_key(input logic [7:0] code);
        logic [5:0] r;
        r = 6'd0;
        case (code)
            8'h45: r = {1'b1, 5'd0};
            8'h16: r = {1'b1, 5'd1};
            8'h1E: r = {1'b1, 5'd2};
            8'h26: r = {1'b1, 5'd3};
            8'h25: r = {1'b1, 5'd4};
            8'h2E: r = {1'b1, 5'd5};
            8'h36: r = {1'b1, 5'd6};
            8'h3D: r = {1'b1, 5'd7};
            8'h3E: r = {1'b1, 5'd8};
            8'h46: r = {1'b1, 5'd9};
            8'h4D: r = {1'b1, 5'd10};
            8'h15: r = {1'b1, 5'd11};
            8'h1D: r = {1'b1, 5'd12};
            8'h24: r = {1'b1, 5'd13};
            8'h2D: r = {1'b1, 5'd14};
            8'h2C: r = {1'b1, 5'd15};
            8'h35: r = {1'b1, 5'd16};
            8'h3C: r = {1'b1, 5'd17};
            8'h43: r = {1'b1, 5'd18};
            8'h44: r = {1'b1, 5'd19};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    logic        tog_q;
    logic        key_event;
    logic        key_hit;
    logic [5:0]  key_dec;
    logic [4:0]  key_idx;
    logic [19:0] kp_cur;
    logic [19:0] kp_nxt;
    logic [15:0] kp1_ext;
    logic [15:0] kp2_ext;
    logic        unused_dout;

    // The upper data nibble carries no select information
    assign unused_dout = &{1'b0, io_dout[7:4]};

    assign key_event = ps2_key[10] ^ tog_q;
    assign key_dec   = decode_key(ps2_key[7:0]);
    assign key_hit   = key_event & ~ps2_key[8] & key_dec[5];
    assign key_idx   = key_dec[4:0];
    assign kp_cur    = {kp2_state, kp1_state};

    // Widened views so any 4-bit select can index safely; digits 10..15 read as not held
    assign kp1_ext = {6'd0, kp1_state};
    assign kp2_ext = {6'd0, kp2_state};

`ifdef STUDIO2_KEYPAD_HOLD_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic [4:0]        hold_idx;
    logic [4:0]        hold_idx_nxt;
    logic              hold_pend;
    logic              hold_pend_nxt;

    // Next bitmap with tapped-key stretching: the most recent press is held for
    // HOLD_CYCLES, and its early release is deferred until the counter expires
    always_comb begin
        kp_nxt        = kp_cur;
        hold_cnt_nxt  = hold_cnt;
        hold_idx_nxt  = hold_idx;
        hold_pend_nxt = hold_pend;
        if (hold_cnt != '0) begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
        // Counter reaches zero on this edge: apply the deferred release now
        if (hold_pend && hold_cnt == HOLD_W'(1)) begin
            kp_nxt[hold_idx] = 1'b0;
            hold_pend_nxt    = 1'b0;
        end
        if (key_hit && ps2_key[9]) begin
            // A new press takes over the hold and flushes any deferred release first
            if (hold_pend) begin
                kp_nxt[hold_idx] = 1'b0;
            end
            kp_nxt[key_idx] = 1'b1;
            hold_pend_nxt   = 1'b0;
            hold_cnt_nxt    = HOLD_W'(HOLD_CYCLES);
            hold_idx_nxt    = key_idx;
        end else if (key_hit) begin
            // A release on the final count expires together with the counter
            if (key_idx == hold_idx && hold_cnt > HOLD_W'(1)) begin
                hold_pend_nxt = 1'b1;
            end else begin
                kp_nxt[key_idx] = 1'b0;
            end
        end
    end

    // Hold counter, hold key and deferred-release flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= '0;
            hold_idx  <= 5'd0;
            hold_pend <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            hold_idx  <= hold_idx_nxt;
            hold_pend <= hold_pend_nxt;
        end
    end
`else
    // Next bitmap: a mapped event writes its pressed bit into the decoded key only
    always_comb begin
        kp_nxt = kp_cur;
        if (key_hit) begin
            kp_nxt[key_idx] = ps2_key[9];
        end
    end
`endif

    // Toggle history, select latch, bitmaps and registered EF flags
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            key_sel   <= 4'd0;
            kp1_state <= 10'd0;
            kp2_state <= 10'd0;
            ef3_n     <= 1'b1;
            ef4_n     <= 1'b1;
        end else begin
            tog_q <= ps2_key[10];
            if (io_out && io_n == SEL_PORT) begin
                key_sel <= io_dout[3:0];
            end
            kp1_state <= kp_nxt[9:0];
            kp2_state <= kp_nxt[19:10];
            ef3_n     <= ~(key_sel < 4'd10 && kp1_ext[key_sel]);
            ef4_n     <= ~(key_sel < 4'd10 && kp2_ext[key_sel]);
        end
    end

endmodule
